// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle from the timing generator to sprite stages and the monitor.
// Signals:
//   DrawX, DrawY  current pixel column / line
//   blank         1 = visible pixel, 0 = blanking
//   hs, vs        active-low syncs aligned with DrawX/DrawY
//   vga_hs/vga_vs syncs delayed one cycle, aligned with registered colour
//   line_start    pulse while DrawX==0
//   frame_start   pulse while DrawX==0 and DrawY==0
//   frame_count   completed-frame counter
interface vga_timing_gen_if;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       vga_hs;
    logic       vga_vs;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_count;
    modport master (
        output DrawX, DrawY, blank, hs, vs, vga_hs, vga_vs, line_start, frame_start, frame_count
    );
    modport slave (
        input DrawX, DrawY, blank, hs, vs, vga_hs, vga_vs, line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 Hz VGA raster counter with registered decodes and monitor-aligned syncs.
// Ports:
//   vga_clk  in   pixel clock, all logic on posedge
//   reset    in   asynchronous, active-high
//   vif      out  vga_timing_gen_if.master timing bundle (coordinates, blank, syncs, pulses, frame count)
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic               vga_clk,
    input  logic               reset,
    vga_timing_gen_if.master   vif
);
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    logic [9:0] hc_q, hc_d, vc_q, vc_d;
    logic       blank_q, blank_d;
    logic       hs_q, hs_d, vs_q, vs_d;
    logic       vga_hs_q, vga_hs_d, vga_vs_q, vga_vs_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;
    logic [7:0] frame_count_q, frame_count_d;
    logic       h_wrap, f_wrap;
    // Decodes use the next-state counters so the registered flags line up with DrawX/DrawY.
    always_comb begin
        h_wrap        = hc_q == H_LAST;
        f_wrap        = h_wrap && vc_q == V_LAST;
        hc_d          = h_wrap ? 10'd0 : hc_q + 10'd1;
        vc_d          = f_wrap ? 10'd0 : h_wrap ? vc_q + 10'd1 : vc_q;
        blank_d       = hc_d < H_VIS && vc_d < V_VIS;
        hs_d          = !(hc_d >= HS_BEG && hc_d < HS_END);
        vs_d          = !(vc_d >= VS_BEG && vc_d < VS_END);
        vga_hs_d      = hs_q;
        vga_vs_d      = vs_q;
        line_start_d  = hc_d == 10'd0;
        frame_start_d = hc_d == 10'd0 && vc_d == 10'd0;
        frame_count_d = frame_count_q + {7'd0, f_wrap};
    end
    // Reset parks the raster at (0,0), so the pulses read 1 while reset is held.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hc_q          <= 10'd0;
            vc_q          <= 10'd0;
            blank_q       <= 1'b1;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            vga_hs_q      <= 1'b1;
            vga_vs_q      <= 1'b1;
            line_start_q  <= 1'b1;
            frame_start_q <= 1'b1;
            frame_count_q <= 8'd0;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            blank_q       <= blank_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            vga_hs_q      <= vga_hs_d;
            vga_vs_q      <= vga_vs_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end
    assign vif.DrawX       = hc_q;
    assign vif.DrawY       = vc_q;
    assign vif.blank       = blank_q;
    assign vif.hs          = hs_q;
    assign vif.vs          = vs_q;
    assign vif.vga_hs      = vga_hs_q;
    assign vif.vga_vs      = vga_vs_q;
    assign vif.line_start  = line_start_q;
    assign vif.frame_start = frame_start_q;
    assign vif.frame_count = frame_count_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks a full-size generator on its first line and a shrunken one over whole frames.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst_d = 1'b1;
    logic rst_s = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [7:0] rgb;
    always #5 clk = ~clk;
    vga_timing_gen_if dif();
    vga_timing_gen_if sif();
    vga_timing_gen dut_d (.vga_clk(clk), .reset(rst_d), .vif(dif));
    // Small raster: 16 cycles per line (hs low at x 10..12), 10 lines per frame (vs low at y 6..7).
    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
    ) dut_s (.vga_clk(clk), .reset(rst_s), .vif(sif));
    // Sprite stage: registers a nonzero colour for every visible pixel.
    always @(posedge clk) rgb <= sif.blank ? 8'(sif.DrawX[3:0]) + 8'd1 : 8'd0;
    typedef struct {
        int         cyc;
        logic [9:0] x;
        logic [9:0] y;
        logic [6:0] fl;
    } vec_t;
    vec_t tbl[12];
    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask
    task automatic chk_st(string nm, logic [9:0] x, logic [9:0] y, logic [6:0] fl, logic [7:0] fc,
                          logic [9:0] ex, logic [9:0] ey, logic [6:0] efl, logic [7:0] efc);
        chk({nm, "_x"}, 32'(x), 32'(ex));
        chk({nm, "_y"}, 32'(y), 32'(ey));
        chk({nm, "_flags"}, 32'(fl), 32'(efl));
        chk({nm, "_fcount"}, 32'(fc), 32'(efc));
    endtask
    // Flag order: {blank, hs, vs, vga_hs, vga_vs, line_start, frame_start}
    function automatic logic [6:0] d_fl();
        return {dif.blank, dif.hs, dif.vs, dif.vga_hs, dif.vga_vs, dif.line_start, dif.frame_start};
    endfunction
    function automatic logic [6:0] s_fl();
        return {sif.blank, sif.hs, sif.vs, sif.vga_hs, sif.vga_vs, sif.line_start, sif.frame_start};
    endfunction
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask
    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int n;
        int blank_n, vs_n, hs_n, fs_n, ls_n, vs_fall, rgb_bad, lag_bad, gap, gap_vhs, since_rise, hs_first, p;
        logic [19:0] vs_first;
        logic prev_blank, prev_hs, prev_vs, prev_vhs;
        tbl[0]  = '{0,   10'd0,   10'd0, 7'b1111111};
        tbl[1]  = '{1,   10'd1,   10'd0, 7'b1111100};
        tbl[2]  = '{639, 10'd639, 10'd0, 7'b1111100};
        tbl[3]  = '{640, 10'd640, 10'd0, 7'b0111100};
        tbl[4]  = '{656, 10'd656, 10'd0, 7'b0011100};
        tbl[5]  = '{657, 10'd657, 10'd0, 7'b0010100};
        tbl[6]  = '{751, 10'd751, 10'd0, 7'b0010100};
        tbl[7]  = '{752, 10'd752, 10'd0, 7'b0110100};
        tbl[8]  = '{753, 10'd753, 10'd0, 7'b0111100};
        tbl[9]  = '{799, 10'd799, 10'd0, 7'b0111100};
        tbl[10] = '{800, 10'd0,   10'd1, 7'b1111110};
        tbl[11] = '{801, 10'd1,   10'd1, 7'b1111100};
        @(negedge clk);
        @(negedge clk);
        chk_st("rst_d", dif.DrawX, dif.DrawY, d_fl(), dif.frame_count, 10'd0, 10'd0, 7'b1111111, 8'd0);
        chk_st("rst_s", sif.DrawX, sif.DrawY, s_fl(), sif.frame_count, 10'd0, 10'd0, 7'b1111111, 8'd0);
        rst_d = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            while (n < tbl[i].cyc) begin
                tick();
                n++;
            end
            chk_st($sformatf("vec%0d", i), dif.DrawX, dif.DrawY, d_fl(), dif.frame_count,
                   tbl[i].x, tbl[i].y, tbl[i].fl, 8'd0);
        end
        rst_s = 1'b0;
        blank_n = 0; vs_n = 0; hs_n = 0; fs_n = 0; ls_n = 0; vs_fall = 0;
        rgb_bad = 0; lag_bad = 0; gap = -1; gap_vhs = 0; since_rise = -1; hs_first = -1;
        vs_first = '1;
        prev_blank = 1'b0; prev_hs = 1'b1; prev_vs = 1'b1; prev_vhs = 1'b1;
        for (int k = 0; k < 160; k++) begin
            if (k > 0) begin
                if ((rgb != 8'd0) != prev_blank) rgb_bad++;
                if (sif.vga_hs !== prev_hs || sif.vga_vs !== prev_vs) lag_bad++;
                if (prev_vs && !sif.vs) vs_fall++;
                if (!prev_vhs && sif.vga_hs) since_rise = 0;
                else if (since_rise >= 0) since_rise++;
                if (since_rise >= 0 && gap < 0 && rgb != 8'd0) begin
                    gap = since_rise;
                    gap_vhs = int'(sif.vga_hs);
                end
            end
            blank_n += int'(sif.blank);
            vs_n += int'(!sif.vs);
            hs_n += int'(!sif.hs);
            fs_n += int'(sif.frame_start);
            ls_n += int'(sif.line_start);
            if (!sif.vs && vs_first == '1) vs_first = {sif.DrawX, sif.DrawY};
            if (!sif.hs && hs_first < 0) hs_first = int'(sif.DrawX);
            prev_blank = sif.blank;
            prev_hs = sif.hs;
            prev_vs = sif.vs;
            prev_vhs = sif.vga_hs;
            if (k == 159)
                chk_st("last_px", sif.DrawX, sif.DrawY, s_fl(), sif.frame_count, 10'd15, 10'd9, 7'b0111100, 8'd0);
            tick();
        end
        chk_st("frame_wrap", sif.DrawX, sif.DrawY, s_fl(), sif.frame_count, 10'd0, 10'd0, 7'b1111111, 8'd1);
        chk("blank_count", blank_n, 32);
        chk("vs_low_count", vs_n, 32);
        chk("vs_fall_count", vs_fall, 1);
        chk("vs_first_xy", 32'(vs_first), {12'd0, 10'd0, 10'd6});
        chk("hs_low_count", hs_n, 30);
        chk("hs_first_x", hs_first, 10);
        chk("fs_pulses", fs_n, 1);
        chk("ls_pulses", ls_n, 10);
        chk("rgb_vs_blank", rgb_bad, 0);
        chk("sync_lag", lag_bad, 0);
        chk("back_porch_gap", gap, 3);
        chk("first_px_vga_hs", gap_vhs, 1);
        for (int k = 0; k < 123; k++) tick();
        chk_st("pre_rst", sif.DrawX, sif.DrawY, s_fl(), sif.frame_count, 10'd11, 10'd7, 7'b0000000, 8'd1);
        #2 rst_s = 1'b1;
        #1 chk_st("async_rst", sif.DrawX, sif.DrawY, s_fl(), sif.frame_count, 10'd0, 10'd0, 7'b1111111, 8'd0);
        @(negedge clk);
        chk_st("rst_hold", sif.DrawX, sif.DrawY, s_fl(), sif.frame_count, 10'd0, 10'd0, 7'b1111111, 8'd0);
        rst_s = 1'b0;
        tick();
        chk_st("post_rst", sif.DrawX, sif.DrawY, s_fl(), sif.frame_count, 10'd1, 10'd0, 7'b1111100, 8'd0);
        for (int k = 0; k < 255 * 160 - 1; k++) tick();
        chk_st("fc_255", sif.DrawX, sif.DrawY, s_fl(), sif.frame_count, 10'd0, 10'd0, 7'b1111111, 8'd255);
        p = 0;
        do begin
            tick();
            p++;
        end while (!sif.frame_start && p < 400);
        chk("fs_period", p, 160);
        chk("fc_wrap", 32'(sif.frame_count), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
